riscv_execute_md: RTL and testbench

//  Parametrised next-generation RV32IM execute stage. Contents:
//   - D->E pipeline register with stall and flush.
//   - Operand forwarding, plus exact signed/unsigned branch compare.

---
 rtl/riscv_execute_md.sv | 218 +++++++++++++++++++++
 tb/tb_riscv_execute_md.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_execute_md.sv
// RV32IM/RV64IM execute stage: D->E pipeline register, operand forwarding, branch
// resolution and an iterative multiply/divide unit that holds the front end while busy.
module riscv_execute_md #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_validD,
  input  logic [3:0]      i_ctrl_alu_ctrlD,
  input  logic            i_ctrl_alu_srcD,
  input  logic            i_ctrl_mdD,
  input  logic            i_ctrl_branchD,
  input  logic            i_ctrl_jalD,
  input  logic            i_ctrl_jalrD,
  input  logic [2:0]      i_ctrl_funct3D,
  input  logic [XLEN-1:0] i_regfile_rs1_dataD,
  input  logic [XLEN-1:0] i_regfile_rs2_dataD,
  input  logic [4:0]      i_regfile_rd_addrD,
  input  logic [XLEN-1:0] i_PCD,
  input  logic [XLEN-1:0] i_ExtImmD,
  input  logic [XLEN-1:0] i_PCPlus4D,
  input  logic [1:0]      i_hazard_forwardAE,
  input  logic [1:0]      i_hazard_forwardBE,
  input  logic            i_hazard_flushE,
  input  logic            i_hazard_stallE,
  input  logic [XLEN-1:0] i_writeback_dataM,
  input  logic [XLEN-1:0] i_regfile_rd_dataW,
  output logic            o_validE,
  output logic [4:0]      o_regfile_rd_addrE,
  output logic [XLEN-1:0] o_alu_resultE,
  output logic [XLEN-1:0] o_mem_writedataE,
  output logic [XLEN-1:0] o_PCTargetE,
  output logic [XLEN-1:0] o_jalr_targetE,
  output logic [XLEN-1:0] o_PCPlus4E,
  output logic [1:0]      o_PCSrcE,
  output logic            o_md_stallE
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_CALC = 2'd1, MD_DONE = 2'd2} mdState_t;

  logic            validE, aluSrcE, mdE, branchE, jalE, jalrE;
  logic [3:0]      aluCtrlE;
  logic [2:0]      funct3E;
  logic [4:0]      rdE;
  logic [XLEN-1:0] rs1E, rs2E, pcE, immE, pcPlus4E;

  mdState_t        mdState;
  logic [CW-1:0]   mdCount;
  logic [XLEN-1:0] mdHi, mdLo, mdOpB;
  logic            mdNeg;

  logic [XLEN-1:0]   srcA, srcB, aluB, aluResult, mdResult, fastResult, aMag, bMag;
  logic [2*XLEN-1:0] prodS, fastA, fastB, fastProd;
  logic [XLEN:0]     mulSum, divShift, divTrial;
  logic              fastOp, mdActive, mdStall, taken, aSigned, bSigned, aNeg, bNeg;
  logic              divZero, divOvf;

  assign fastOp   = FAST_MUL && !funct3E[2];
  assign mdActive = validE && mdE && !fastOp;
  assign mdStall  = mdActive && (mdState != MD_DONE);

  // D->E pipeline register: flush beats stall beats load
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn || i_hazard_flushE) begin
      validE <= 1'b0; aluCtrlE <= 4'd0; aluSrcE <= 1'b0; mdE <= 1'b0;
      branchE <= 1'b0; jalE <= 1'b0; jalrE <= 1'b0; funct3E <= 3'd0; rdE <= 5'd0;
      rs1E <= '0; rs2E <= '0; pcE <= '0; immE <= '0; pcPlus4E <= '0;
    end else if (!(i_hazard_stallE || mdStall)) begin
      validE <= i_validD; aluCtrlE <= i_ctrl_alu_ctrlD; aluSrcE <= i_ctrl_alu_srcD;
      mdE <= i_ctrl_mdD; branchE <= i_ctrl_branchD; jalE <= i_ctrl_jalD; jalrE <= i_ctrl_jalrD;
      funct3E <= i_ctrl_funct3D; rdE <= i_regfile_rd_addrD;
      rs1E <= i_regfile_rs1_dataD; rs2E <= i_regfile_rs2_dataD;
      pcE <= i_PCD; immE <= i_ExtImmD; pcPlus4E <= i_PCPlus4D;
    end
  end

  // Operand forwarding; select 11 falls back to the register value
  always_comb begin
    case (i_hazard_forwardAE)
      2'b10:   srcA = i_writeback_dataM;
      2'b01:   srcA = i_regfile_rd_dataW;
      default: srcA = rs1E;
    endcase
    case (i_hazard_forwardBE)
      2'b10:   srcB = i_writeback_dataM;
      2'b01:   srcB = i_regfile_rd_dataW;
      default: srcB = rs2E;
    endcase
    aluB = aluSrcE ? immE : srcB;
  end

  // Integer ALU
  always_comb begin
    case (aluCtrlE)
      4'd0:    aluResult = srcA + aluB;
      4'd1:    aluResult = srcA - aluB;
      4'd2:    aluResult = srcA & aluB;
      4'd3:    aluResult = srcA | aluB;
      4'd4:    aluResult = srcA ^ aluB;
      4'd5:    aluResult = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(aluB)};
      4'd6:    aluResult = {{(XLEN-1){1'b0}}, srcA < aluB};
      4'd7:    aluResult = srcA << aluB[CW-1:0];
      4'd8:    aluResult = srcA >> aluB[CW-1:0];
      4'd9:    aluResult = $signed(srcA) >>> aluB[CW-1:0];
      4'd10:   aluResult = aluB;
      default: aluResult = {XLEN{1'b0}};
    endcase
  end

  // Branch condition and next-PC select
  always_comb begin
    case (funct3E)
      3'b000:  taken = (srcA == srcB);
      3'b001:  taken = (srcA != srcB);
      3'b100:  taken = ($signed(srcA) < $signed(srcB));
      3'b101:  taken = !($signed(srcA) < $signed(srcB));
      3'b110:  taken = (srcA < srcB);
      3'b111:  taken = !(srcA < srcB);
      default: taken = 1'b0;
    endcase
    if (validE && jalrE) begin
      o_PCSrcE = 2'b10;
    end else if (validE && (jalE || (branchE && taken))) begin
      o_PCSrcE = 2'b01;
    end else begin
      o_PCSrcE = 2'b00;
    end
  end

  // Operand magnitudes, result sign and divide special cases, sampled when an op starts
  always_comb begin
    aSigned  = (funct3E == 3'd1) || (funct3E == 3'd2) || (funct3E == 3'd4) || (funct3E == 3'd6);
    bSigned  = (funct3E == 3'd1) || (funct3E == 3'd4) || (funct3E == 3'd6);
    aNeg     = aSigned && srcA[XLEN-1];
    bNeg     = bSigned && srcB[XLEN-1];
    aMag     = aNeg ? -srcA : srcA;
    bMag     = bNeg ? -srcB : srcB;
    divZero  = funct3E[2] && (srcB == {XLEN{1'b0}});
    divOvf   = funct3E[2] && !funct3E[0] && (srcA == {1'b1, {(XLEN-1){1'b0}}})
               && (srcB == {XLEN{1'b1}});
    mulSum   = {1'b0, mdHi} + (mdLo[0] ? {1'b0, mdOpB} : {(XLEN+1){1'b0}});
    divShift = {mdHi, mdLo[XLEN-1]};
    divTrial = divShift - {1'b0, mdOpB};
    fastA    = {{XLEN{aNeg}}, srcA};
    fastB    = {{XLEN{bNeg}}, srcB};
    fastProd = fastA * fastB;
  end

  // Result selection: mdHi:mdLo holds product, or remainder:quotient
  always_comb begin
    prodS = mdNeg ? -{mdHi, mdLo} : {mdHi, mdLo};
    case (funct3E)
      3'd0:                mdResult = prodS[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    mdResult = prodS[2*XLEN-1:XLEN];
      3'd4, 3'd5:          mdResult = mdNeg ? -mdLo : mdLo;
      default:             mdResult = mdNeg ? -mdHi : mdHi;
    endcase
    fastResult = (funct3E == 3'd0) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
    if (!mdE) begin
      o_alu_resultE = aluResult;
    end else if (fastOp) begin
      o_alu_resultE = fastResult;
    end else begin
      o_alu_resultE = mdResult;
    end
  end

  // Multiply/divide sequencer: one product or quotient bit per cycle
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mdState <= MD_IDLE; mdCount <= '0; mdHi <= '0; mdLo <= '0; mdOpB <= '0; mdNeg <= 1'b0;
    end else if (i_hazard_flushE) begin
      mdState <= MD_IDLE;
    end else begin
      case (mdState)
        MD_IDLE: if (mdActive) begin
          mdCount <= '0;
          if (divZero) begin
            mdHi <= srcA; mdLo <= {XLEN{1'b1}}; mdOpB <= srcB; mdNeg <= 1'b0; mdState <= MD_DONE;
          end else if (divOvf) begin
            mdHi <= '0; mdLo <= srcA; mdOpB <= srcB; mdNeg <= 1'b0; mdState <= MD_DONE;
          end else begin
            mdHi <= '0; mdLo <= aMag; mdOpB <= bMag;
            mdNeg <= (funct3E[2] && funct3E[1]) ? aNeg : (aNeg ^ bNeg);
            mdState <= MD_CALC;
          end
        end
        MD_CALC: begin
          if (!funct3E[2]) begin
            mdHi <= mulSum[XLEN:1]; mdLo <= {mulSum[0], mdLo[XLEN-1:1]};
          end else if (!divTrial[XLEN]) begin
            mdHi <= divTrial[XLEN-1:0]; mdLo <= {mdLo[XLEN-2:0], 1'b1};
          end else begin
            mdHi <= divShift[XLEN-1:0]; mdLo <= {mdLo[XLEN-2:0], 1'b0};
          end
          mdCount <= mdCount + CW'(1);
          if (mdCount == CW'(XLEN-1)) mdState <= MD_DONE;
        end
        MD_DONE: if (!i_hazard_stallE) mdState <= MD_IDLE;
        default: mdState <= MD_IDLE;
      endcase
    end
  end

  assign o_md_stallE        = mdStall;
  assign o_validE           = validE && !mdStall;
  assign o_regfile_rd_addrE = rdE;
  assign o_mem_writedataE   = srcB;
  assign o_PCTargetE        = pcE + immE;
  assign o_jalr_targetE     = {o_jalrSum_hi(srcA + immE), 1'b0};
  assign o_PCPlus4E         = pcPlus4E;

  function automatic logic [XLEN-2:0] o_jalrSum_hi(input logic [XLEN-1:0] sum);
    return sum[XLEN-1:1];
  endfunction
endmodule

// File: tb/tb_riscv_execute_md.sv
// Scoreboard bench for riscv_execute_md: randomized and directed instructions checked
// against an arithmetic reference model; a FAST_MUL=1 twin checks single-cycle multiplies.
`timescale 1ns/1ps
module tb_riscv_execute_md;
  logic        clk = 1'b0, rstn;
  logic        validD, aluSrcD, mdD, branchD, jalD, jalrD, flushE, stallE;
  logic [3:0]  aluCtrlD;
  logic [2:0]  funct3D;
  logic [31:0] rs1D, rs2D, pcD, immD, pcPlus4D, dataM, dataW;
  logic [4:0]  rdD;
  logic [1:0]  fwdA, fwdB;
  logic        validE, mdStall, fValidE, fMdStall, fStallIn;
  logic [4:0]  rdE, fRdE;
  logic [31:0] resE, wdE, tgtE, jtgtE, p4E, fResE, fWdE, fTgtE, fJtgtE, fP4E;
  logic [1:0]  pcSrcE, fPcSrcE;

  always #5 clk = ~clk;
  assign fStallIn = stallE | mdStall;

  riscv_execute_md #(.XLEN(32), .FAST_MUL(1'b0)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_validD(validD), .i_ctrl_alu_ctrlD(aluCtrlD),
    .i_ctrl_alu_srcD(aluSrcD), .i_ctrl_mdD(mdD), .i_ctrl_branchD(branchD), .i_ctrl_jalD(jalD),
    .i_ctrl_jalrD(jalrD), .i_ctrl_funct3D(funct3D), .i_regfile_rs1_dataD(rs1D),
    .i_regfile_rs2_dataD(rs2D), .i_regfile_rd_addrD(rdD), .i_PCD(pcD), .i_ExtImmD(immD),
    .i_PCPlus4D(pcPlus4D), .i_hazard_forwardAE(fwdA), .i_hazard_forwardBE(fwdB),
    .i_hazard_flushE(flushE), .i_hazard_stallE(stallE), .i_writeback_dataM(dataM),
    .i_regfile_rd_dataW(dataW), .o_validE(validE), .o_regfile_rd_addrE(rdE),
    .o_alu_resultE(resE), .o_mem_writedataE(wdE), .o_PCTargetE(tgtE),
    .o_jalr_targetE(jtgtE), .o_PCPlus4E(p4E), .o_PCSrcE(pcSrcE), .o_md_stallE(mdStall));

  riscv_execute_md #(.XLEN(32), .FAST_MUL(1'b1)) fast (
    .i_clk(clk), .i_rstn(rstn), .i_validD(validD), .i_ctrl_alu_ctrlD(aluCtrlD),
    .i_ctrl_alu_srcD(aluSrcD), .i_ctrl_mdD(mdD), .i_ctrl_branchD(branchD), .i_ctrl_jalD(jalD),
    .i_ctrl_jalrD(jalrD), .i_ctrl_funct3D(funct3D), .i_regfile_rs1_dataD(rs1D),
    .i_regfile_rs2_dataD(rs2D), .i_regfile_rd_addrD(rdD), .i_PCD(pcD), .i_ExtImmD(immD),
    .i_PCPlus4D(pcPlus4D), .i_hazard_forwardAE(fwdA), .i_hazard_forwardBE(fwdB),
    .i_hazard_flushE(flushE), .i_hazard_stallE(fStallIn), .i_writeback_dataM(dataM),
    .i_regfile_rd_dataW(dataW), .o_validE(fValidE), .o_regfile_rd_addrE(fRdE),
    .o_alu_resultE(fResE), .o_mem_writedataE(fWdE), .o_PCTargetE(fTgtE),
    .o_jalr_targetE(fJtgtE), .o_PCPlus4E(fP4E), .o_PCSrcE(fPcSrcE), .o_md_stallE(fMdStall));

  typedef struct {
    logic md, aluSrc, branch, jal, jalr;
    logic [3:0] aluCtrl; logic [2:0] f3; logic [4:0] rd; logic [1:0] fA, fB;
    logic [31:0] rs1, rs2, pc, imm, m, w;
  } instr_t;
  typedef struct {
    logic isMd; logic [4:0] rd; logic [1:0] pcSrc;
    logic [31:0] result, pcPlus4, writeData, pcTarget, jalrTarget;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int nCompared = 0, nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r,
                                      input logic [31:0] m, input logic [31:0] w);
    if (s == 2'b10) return m;
    else if (s == 2'b01) return w;
    else return r;
  endfunction

  function automatic logic [31:0] mdRef(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 32'd0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return 32'(sa / sb);
      3'd5: if (b == 32'd0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 32'd0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return 32'(sa % sb);
      default: if (b == 32'd0) return a; else return a % b;
    endcase
  endfunction

  function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return 32'($signed(a) >>> sh);
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic takenRef(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  function automatic instr_t mk(input logic md, input logic [2:0] f3, input logic [3:0] op,
                                input logic [31:0] rs1, input logic [31:0] rs2);
    instr_t i;
    i.md = md; i.f3 = f3; i.aluCtrl = op; i.aluSrc = 1'b0;
    i.branch = 1'b0; i.jal = 1'b0; i.jalr = 1'b0;
    i.rd = 5'($urandom_range(1, 31)); i.fA = 2'b00; i.fB = 2'b00;
    i.rs1 = rs1; i.rs2 = rs2; i.pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    i.imm = $urandom(); i.m = $urandom(); i.w = $urandom();
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    int k;
    k = $urandom_range(0, 9);
    i = mk(k < 4, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 11)), pickVal(), pickVal());
    i.fA = 2'($urandom_range(0, 3)); i.fB = 2'($urandom_range(0, 3));
    i.m = pickVal(); i.w = pickVal();
    i.aluSrc = (k >= 4 && k <= 6) ? 1'($urandom_range(0, 1)) : 1'b0;
    i.branch = (k == 7); i.jal = (k == 8); i.jalr = (k == 9);
    return i;
  endfunction

  task automatic driveD(input instr_t i);
    aluCtrlD = i.aluCtrl; aluSrcD = i.aluSrc; mdD = i.md; branchD = i.branch;
    jalD = i.jal; jalrD = i.jalr; funct3D = i.f3; rs1D = i.rs1; rs2D = i.rs2;
    rdD = i.rd; pcD = i.pc; immD = i.imm; pcPlus4D = i.pc + 32'd4;
  endtask

  task automatic finishNow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  endtask

  // Issue one instruction (followed by a bubble); flushAt = stalled cycle to flush on, hold = DONE hold cycles
  task automatic runInstr(input instr_t i, input int flushAt, input int hold);
    exp_t e;
    logic [31:0] a, b;
    int n, expStall;
    bit done;
    driveD(i); validD = 1'b1;
    @(posedge clk); #1;
    validD = 1'b0;
    fwdA = i.fA; fwdB = i.fB; dataM = i.m; dataW = i.w;
    a = fwd(i.fA, i.rs1, i.m, i.w);
    b = fwd(i.fB, i.rs2, i.m, i.w);
    e.isMd = i.md; e.rd = i.rd; e.pcPlus4 = i.pc + 32'd4; e.writeData = b;
    e.pcTarget = i.pc + i.imm; e.jalrTarget = (a + i.imm) & 32'hFFFF_FFFE;
    e.result = i.md ? mdRef(i.f3, a, b) : aluRef(i.aluCtrl, a, i.aluSrc ? i.imm : b);
    e.pcSrc = i.jalr ? 2'b10 : ((i.jal || (i.branch && takenRef(i.f3, a, b))) ? 2'b01 : 2'b00);
    for (int k = 0; k <= hold; k++) expQ.push_back(e);
    if (!i.md) expStall = 0;
    else if (i.f3[2] && (b == 32'd0 || (!i.f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      expStall = 1;
    else expStall = 33;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (n == 0 && i.md && !i.f3[2]) begin
        check("fast_mul_stall", 32'(fMdStall), 32'd0);
        check("fast_mul_valid", 32'(fValidE), 32'd1);
        check("fast_mul_result", fResE, e.result);
      end
      if (!mdStall) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 100) begin
          nCompared++; nMismatched++;
          $display("FAIL stall_timeout: actual >100 cycles required %0d", expStall);
          finishNow();
        end else if (n == flushAt) begin
          flushE = 1'b1;
          @(posedge clk); #1;
          flushE = 1'b0;
          check("flush_stall", 32'(mdStall), 32'd0);
          check("flush_valid", 32'(validE), 32'd0);
          for (int k = 0; k <= hold; k++) void'(expQ.pop_back());
          return;
        end else begin
          @(posedge clk); #1;
          dataM = $urandom(); dataW = $urandom();
        end
      end
    end
    check("stall_cycles", 32'(n), 32'(expStall));
    if (hold > 0) begin
      stallE = 1'b1;
      repeat (hold) @(posedge clk);
      #1 stallE = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every valid E slot consumes one expected entry
  always @(negedge clk) begin
    if (rstn && validE) begin
      if (expQ.size() == 0) begin
        nCompared++; nMismatched++;
        $display("FAIL unexpected_valid: actual result 0x%08h required no output", resE);
      end else begin
        monE = expQ.pop_front();
        check("rd", 32'(rdE), 32'(monE.rd));
        check("result", resE, monE.result);
        check("pcsrc", 32'(pcSrcE), 32'(monE.pcSrc));
        check("pcplus4", p4E, monE.pcPlus4);
        if (!monE.isMd) begin
          check("writedata", wdE, monE.writeData);
          check("pctarget", tgtE, monE.pcTarget);
          check("jalr_target", jtgtE, monE.jalrTarget);
        end
      end
    end
  end

  initial begin
    instr_t i;
    rstn = 1'b0; validD = 1'b0; flushE = 1'b0; stallE = 1'b0;
    driveD(mk(1'b0, 3'd0, 4'd0, 32'd0, 32'd0));
    fwdA = 2'b00; fwdB = 2'b00; dataM = 32'd0; dataW = 32'd0;
    #1;
    check("reset_valid", 32'(validE), 32'd0);
    check("reset_stall", 32'(mdStall), 32'd0);
    check("reset_pcsrc", 32'(pcSrcE), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // Asynchronous reset in the middle of a divide
    driveD(mk(1'b1, 3'd4, 4'd0, 32'hFFFF_FFF9, 32'd2)); validD = 1'b1;
    @(posedge clk); #1 validD = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    check("pre_reset_stall", 32'(mdStall), 32'd1);
    rstn = 1'b0;
    #1;
    check("midcalc_reset_stall", 32'(mdStall), 32'd0);
    check("midcalc_reset_pcsrc", 32'(pcSrcE), 32'd0);
    check("midcalc_reset_valid", 32'(validE), 32'd0);
    @(negedge clk) rstn = 1'b1;

    runInstr(mk(1'b1, 3'd4, 4'd0, 32'hFFFF_FFF9, 32'd2), 0, 0);
    runInstr(mk(1'b1, 3'd6, 4'd0, 32'hFFFF_FFF9, 32'd2), 0, 0);
    runInstr(mk(1'b1, 3'd5, 4'd0, 32'd5, 32'd0), 0, 0);
    runInstr(mk(1'b1, 3'd4, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF), 0, 0);
    runInstr(mk(1'b1, 3'd6, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF), 0, 0);
    runInstr(mk(1'b1, 3'd1, 4'd0, 32'h8000_0000, 32'h8000_0000), 0, 0);
    runInstr(mk(1'b1, 3'd3, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 0, 0);
    i = mk(1'b0, 3'd4, 4'd0, 32'hFFFF_FFFF, 32'd1); i.branch = 1'b1;
    runInstr(i, 0, 0);
    i.f3 = 3'd6;
    runInstr(i, 0, 0);
    i = mk(1'b0, 3'd0, 4'd0, 32'h0000_7777, 32'd0); i.jalr = 1'b1;
    i.fA = 2'b10; i.m = 32'h0000_1001; i.imm = 32'd2;
    runInstr(i, 0, 0);
    runInstr(mk(1'b1, 3'd4, 4'd0, 32'd1000, 32'd7), 0, 2);
    runInstr(mk(1'b1, 3'd4, 4'd0, 32'hFFFF_FFF9, 32'd2), 11, 0);
    i = mk(1'b0, 3'd0, 4'd0, 32'd5, 32'd6); i.fA = 2'b10; i.fB = 2'b01;
    runInstr(i, 0, 0);

    for (int k = 0; k < 150; k++) begin
      i = randInstr();
      runInstr(i, (i.md && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : 0,
               ($urandom_range(0, 4) == 0) ? 1 : 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(expQ.size()), 32'd0);
    finishNow();
  end
endmodule
